// File: rtl/collision_scan.sv
// Tile-map collision scanner: once per frame tick, probes eight points around the
// player box in the tile map and commits contact flags plus snap positions together.
module collision_scan #(
    parameter int TILE_SHIFT = 4,
    parameter int MAP_COLS   = 40,
    parameter int SCREEN_W   = 640,
    parameter int SCREEN_H   = 480
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        frame_clk,
    input  logic [9:0]  BallX,
    input  logic [9:0]  BallY,
    input  logic [9:0]  BallS,
    output logic [10:0] map_addr,
    input  logic        map_data,
    output logic        touch_down,
    output logic        touch_up,
    output logic        touch_left,
    output logic        touch_right,
    output logic [9:0]  touch_down_position_y,
    output logic [9:0]  touch_up_position_y,
    output logic [9:0]  touch_left_position_x,
    output logic [9:0]  touch_right_position_x,
    output logic        logic_in_air,
    output logic        scan_done,
    output logic        scan_overrun
);
    typedef enum logic [1:0] {IDLE, PROBE, CHECK, COMMIT} state_t;

    state_t      state_q, state_d;
    logic        fs1_q, fs1_d, fs2_q, fs2_d, fe_q, fe_d;
    logic [2:0]  k_q, k_d;
    logic [9:0]  x_q, x_d, y_q, y_d, s_q, s_d;
    logic [3:0]  hit_q, hit_d;  // bit order: down, up, left, right
    logic [10:0] map_addr_q, map_addr_d;
    logic [3:0]  touch_q, touch_d;
    logic [9:0]  dpy_q, dpy_d, upy_q, upy_d, lpx_q, lpx_d, rpx_q, rpx_d;
    logic        scan_done_q, scan_done_d, overrun_q, overrun_d;

    logic        start, in_range, floor_hit, probe_hit;
    logic [9:0]  s1, px, py, yd, yu, xl, xr, dpos, upos, lpos, rpos;
    logic [10:0] probe_addr;

    always_comb begin
        s1 = s_q + 10'd1;
        px = x_q + s1;
        py = y_q + s_q;
        case (k_q)
            3'd0: begin px = x_q - s_q; py = y_q + s1;  end
            3'd1: begin px = x_q + s_q; py = y_q + s1;  end
            3'd2: begin px = x_q - s_q; py = y_q - s1;  end
            3'd3: begin px = x_q + s_q; py = y_q - s1;  end
            3'd4: begin px = x_q - s1;  py = y_q - s_q; end
            3'd5: begin px = x_q - s1;  py = y_q + s_q; end
            3'd6: begin px = x_q + s1;  py = y_q - s_q; end
            default: begin px = x_q + s1; py = y_q + s_q; end
        endcase
        in_range   = (px < 10'(SCREEN_W)) && (py < 10'(SCREEN_H));
        // Only the two bottom probes treat the area below the screen as solid floor.
        floor_hit  = (k_q[2:1] == 2'd0) && (py >= 10'(SCREEN_H)) && (px < 10'(SCREEN_W));
        probe_hit  = in_range ? map_data : floor_hit;
        probe_addr = 11'(py >> TILE_SHIFT) * 11'(MAP_COLS) + 11'(px >> TILE_SHIFT);

        yd = y_q + s1;
        yu = y_q - s1;
        xl = x_q - s1;
        xr = x_q + s1;
        dpos = (yd >= 10'(SCREEN_H)) ? 10'(SCREEN_H - 1) - s_q
                                     : ((yd >> TILE_SHIFT) << TILE_SHIFT) - 10'd1 - s_q;
        upos = ((yu >> TILE_SHIFT) << TILE_SHIFT) + 10'(1 << TILE_SHIFT) + s_q;
        lpos = ((xl >> TILE_SHIFT) << TILE_SHIFT) + 10'(1 << TILE_SHIFT) + s_q;
        rpos = ((xr >> TILE_SHIFT) << TILE_SHIFT) - 10'd1 - s_q;
    end

    always_comb begin
        fs1_d       = frame_clk;
        fs2_d       = fs1_q;
        fe_d        = fs2_q;
        start       = fs2_q & ~fe_q;
        state_d     = state_q;
        k_d         = k_q;
        x_d         = x_q;
        y_d         = y_q;
        s_d         = s_q;
        hit_d       = hit_q;
        map_addr_d  = map_addr_q;
        touch_d     = touch_q;
        dpy_d       = dpy_q;
        upy_d       = upy_q;
        lpx_d       = lpx_q;
        rpx_d       = rpx_q;
        scan_done_d = 1'b0;
        overrun_d   = overrun_q | (start && (state_q != IDLE));
        case (state_q)
            IDLE: if (start) begin
                x_d     = BallX;
                y_d     = BallY;
                s_d     = BallS;
                hit_d   = '0;
                k_d     = '0;
                state_d = PROBE;
            end
            PROBE: begin
                map_addr_d = in_range ? probe_addr : 11'd0;
                state_d    = CHECK;
            end
            CHECK: begin
                hit_d[k_q[2:1]] = hit_q[k_q[2:1]] | probe_hit;
                k_d             = k_q + 3'd1;
                state_d         = (k_q == 3'd7) ? COMMIT : PROBE;
            end
            default: begin
                touch_d     = hit_q;
                dpy_d       = hit_q[0] ? dpos : 10'd0;
                upy_d       = hit_q[1] ? upos : 10'd0;
                lpx_d       = hit_q[2] ? lpos : 10'd0;
                rpx_d       = hit_q[3] ? rpos : 10'd0;
                scan_done_d = 1'b1;
                state_d     = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= IDLE;
            fs1_q       <= 1'b0;
            fs2_q       <= 1'b0;
            fe_q        <= 1'b0;
            k_q         <= '0;
            x_q         <= '0;
            y_q         <= '0;
            s_q         <= '0;
            hit_q       <= '0;
            map_addr_q  <= '0;
            touch_q     <= '0;
            dpy_q       <= '0;
            upy_q       <= '0;
            lpx_q       <= '0;
            rpx_q       <= '0;
            scan_done_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            fs1_q       <= fs1_d;
            fs2_q       <= fs2_d;
            fe_q        <= fe_d;
            k_q         <= k_d;
            x_q         <= x_d;
            y_q         <= y_d;
            s_q         <= s_d;
            hit_q       <= hit_d;
            map_addr_q  <= map_addr_d;
            touch_q     <= touch_d;
            dpy_q       <= dpy_d;
            upy_q       <= upy_d;
            lpx_q       <= lpx_d;
            rpx_q       <= rpx_d;
            scan_done_q <= scan_done_d;
            overrun_q   <= overrun_d;
        end
    end

    assign map_addr               = map_addr_q;
    assign touch_down             = touch_q[0];
    assign touch_up               = touch_q[1];
    assign touch_left             = touch_q[2];
    assign touch_right            = touch_q[3];
    assign touch_down_position_y  = dpy_q;
    assign touch_up_position_y    = upy_q;
    assign touch_left_position_x  = lpx_q;
    assign touch_right_position_x = rpx_q;
    assign logic_in_air           = ~touch_q[0];
    assign scan_done              = scan_done_q;
    assign scan_overrun           = overrun_q;
endmodule

// File: tb/tb_collision_scan.sv
// Bench for collision_scan: fixed vectors, overrun/reset sequences and random scans
// against a tile-map reference model.
module tb_collision_scan;
    logic        Clk, Reset_n, frame_clk, map_data;
    logic [9:0]  BallX, BallY, BallS;
    logic [10:0] map_addr;
    logic        touch_down, touch_up, touch_left, touch_right, logic_in_air;
    logic [9:0]  touch_down_position_y, touch_up_position_y;
    logic [9:0]  touch_left_position_x, touch_right_position_x;
    logic        scan_done, scan_overrun;

    collision_scan dut (
        .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk),
        .BallX(BallX), .BallY(BallY), .BallS(BallS),
        .map_addr(map_addr), .map_data(map_data),
        .touch_down(touch_down), .touch_up(touch_up),
        .touch_left(touch_left), .touch_right(touch_right),
        .touch_down_position_y(touch_down_position_y),
        .touch_up_position_y(touch_up_position_y),
        .touch_left_position_x(touch_left_position_x),
        .touch_right_position_x(touch_right_position_x),
        .logic_in_air(logic_in_air), .scan_done(scan_done), .scan_overrun(scan_overrun)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic map_mem [0:1199];
    assign map_data = (map_addr < 11'd1200) ? map_mem[map_addr] : 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input int td, tu, tl, tr, dpy, upy, lpx, rpx);
        chk({tag, ".touch_down"}, 64'(touch_down), 64'(td));
        chk({tag, ".touch_up"}, 64'(touch_up), 64'(tu));
        chk({tag, ".touch_left"}, 64'(touch_left), 64'(tl));
        chk({tag, ".touch_right"}, 64'(touch_right), 64'(tr));
        chk({tag, ".down_y"}, 64'(touch_down_position_y), 64'(dpy));
        chk({tag, ".up_y"}, 64'(touch_up_position_y), 64'(upy));
        chk({tag, ".left_x"}, 64'(touch_left_position_x), 64'(lpx));
        chk({tag, ".right_x"}, 64'(touch_right_position_x), 64'(rpx));
        chk({tag, ".in_air"}, 64'(logic_in_air), 64'(td == 0));
    endtask

    // Reference model results
    int m_addr [8];
    int m_td, m_tu, m_tl, m_tr, m_dpy, m_upy, m_lpx, m_rpx;

    task automatic model(input int X, Y, S);
        int xs [8];
        int ys [8];
        int hit [4];
        int px, py, yd, yu, xl, xr;
        bit inr, res;
        xs = '{X-S, X+S, X-S, X+S, X-S-1, X-S-1, X+S+1, X+S+1};
        ys = '{Y+S+1, Y+S+1, Y-S-1, Y-S-1, Y-S, Y+S, Y-S, Y+S};
        hit = '{0, 0, 0, 0};
        for (int k = 0; k < 8; k++) begin
            px  = xs[k] & 1023;
            py  = ys[k] & 1023;
            inr = (px < 640) && (py < 480);
            m_addr[k] = inr ? (py / 16) * 40 + px / 16 : 0;
            res = inr ? map_mem[m_addr[k]] : (k < 2 && py >= 480 && px < 640);
            if (res) hit[k/2] = 1;
        end
        yd = (Y + S + 1) & 1023;
        yu = (Y - S - 1) & 1023;
        xl = (X - S - 1) & 1023;
        xr = (X + S + 1) & 1023;
        m_td = hit[0]; m_tu = hit[1]; m_tl = hit[2]; m_tr = hit[3];
        m_dpy = !hit[0] ? 0 : (yd >= 480) ? (479 - S) & 1023 : ((yd / 16) * 16 - 1 - S) & 1023;
        m_upy = !hit[1] ? 0 : ((yu / 16 + 1) * 16 + S) & 1023;
        m_lpx = !hit[2] ? 0 : ((xl / 16 + 1) * 16 + S) & 1023;
        m_rpx = !hit[3] ? 0 : ((xr / 16) * 16 - 1 - S) & 1023;
    endtask

    task automatic set_map(input int kind);
        for (int i = 0; i < 1200; i++) begin
            case (kind)
                1: map_mem[i] = (i / 40 == 17);
                2: map_mem[i] = (i % 40 == 5);
                3: map_mem[i] = (i % 40 == 10);
                default: map_mem[i] = 1'b0;
            endcase
        end
    endtask

    // Edge e counts Clk edges after the frame_clk rise; edge e is E(e-3).
    task automatic run_scan(input string tag, input int X, Y, S, input bit ovr, input bit rst_mid);
        int pulses, pulse_e;
        logic [43:0] pre;
        logic [10:0] got_addr [8];
        pre = {touch_down, touch_up, touch_left, touch_right, touch_down_position_y,
               touch_up_position_y, touch_left_position_x, touch_right_position_x};
        model(X, Y, S);
        pulses = 0;
        pulse_e = -1;
        @(posedge Clk); #1;
        BallX = 10'(X); BallY = 10'(Y); BallS = 10'(S);
        frame_clk = 1'b1;
        for (int e = 1; e <= 23; e++) begin
            @(posedge Clk); #1;
            if (scan_done) begin pulses++; pulse_e = e; end
            if (e == 2) frame_clk = 1'b0;
            if (ovr && e == 3) begin BallX = 10'd320; BallY = 10'd240; BallS = 10'd15; end
            if (ovr && e == 8) frame_clk = 1'b1;
            if (ovr && e == 11) frame_clk = 1'b0;
            if (e >= 4 && e <= 18 && (e % 2 == 0)) got_addr[(e - 4) / 2] = map_addr;
            if (!rst_mid && e == 19)
                chk({tag, ".hold"}, 64'({touch_down, touch_up, touch_left, touch_right,
                    touch_down_position_y, touch_up_position_y, touch_left_position_x,
                    touch_right_position_x}), 64'(pre));
            if (rst_mid && e == 12) begin
                Reset_n = 1'b0;
                #1;
                chk_outs({tag, ".rst"}, 0, 0, 0, 0, 0, 0, 0, 0);
                chk({tag, ".rst.done"}, 64'(scan_done), 64'd0);
                chk({tag, ".rst.ovr"}, 64'(scan_overrun), 64'd0);
                chk({tag, ".rst.addr"}, 64'(map_addr), 64'd0);
            end
            if (rst_mid && e == 14) Reset_n = 1'b1;
        end
        if (rst_mid) begin
            chk({tag, ".done_cnt"}, 64'(pulses), 64'd0);
        end else begin
            chk({tag, ".done_cnt"}, 64'(pulses), 64'd1);
            chk({tag, ".done_edge"}, 64'(pulse_e), 64'd20);
            for (int k = 0; k < 8; k++)
                chk($sformatf("%s.addr%0d", tag, k), 64'(got_addr[k]), 64'(m_addr[k]));
        end
    endtask

    typedef struct {
        int kind, x, y, s;
        int td, tu, tl, tr, dpy, upy, lpx, rpx;
    } vec_t;

    vec_t vec [7];

    initial begin
        vec[0] = '{0, 320, 240, 15, 0, 0, 0, 0, 0,   0,   0,   0};
        vec[1] = '{1, 100, 256, 15, 1, 0, 0, 0, 256, 0,   0,   0};
        vec[2] = '{2, 111, 200, 15, 0, 0, 1, 0, 0,   0,   111, 0};
        vec[3] = '{3, 144, 200, 15, 0, 0, 0, 1, 0,   0,   0,   144};
        vec[4] = '{0, 10,  470, 15, 1, 0, 0, 0, 464, 0,   0,   0};
        vec[5] = '{0, 100, 15,  15, 0, 0, 0, 0, 0,   0,   0,   0};
        vec[6] = '{1, 100, 300, 15, 0, 1, 1, 1, 0,   303, 111, 96};

        frame_clk = 1'b0;
        BallX = '0; BallY = '0; BallS = '0;
        set_map(0);
        Reset_n = 1'b1;
        #3 Reset_n = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        chk_outs("reset", 0, 0, 0, 0, 0, 0, 0, 0);
        chk("reset.done", 64'(scan_done), 64'd0);
        chk("reset.ovr", 64'(scan_overrun), 64'd0);
        chk("reset.addr", 64'(map_addr), 64'd0);
        Reset_n = 1'b1;
        repeat (2) @(posedge Clk);

        for (int i = 0; i < 7; i++) begin
            set_map(vec[i].kind);
            run_scan($sformatf("vec%0d", i), vec[i].x, vec[i].y, vec[i].s, 1'b0, 1'b0);
            chk_outs($sformatf("vec%0d", i), vec[i].td, vec[i].tu, vec[i].tl, vec[i].tr,
                     vec[i].dpy, vec[i].upy, vec[i].lpx, vec[i].rpx);
        end
        chk("pre_ovr", 64'(scan_overrun), 64'd0);

        // Second frame edge mid-scan: dropped, sticky overrun, first snapshot wins.
        set_map(3);
        run_scan("ovr", 144, 200, 15, 1'b1, 1'b0);
        chk_outs("ovr", 0, 0, 0, 1, 0, 0, 0, 144);
        chk("ovr.flag", 64'(scan_overrun), 64'd1);

        // Reset in the middle of a scan discards it.
        set_map(1);
        run_scan("prep", 100, 256, 15, 1'b0, 1'b0);
        chk("prep.ovr_sticky", 64'(scan_overrun), 64'd1);
        chk("prep.td", 64'(touch_down), 64'd1);
        run_scan("rstmid", 100, 256, 15, 1'b0, 1'b1);
        chk_outs("rstmid.after", 0, 0, 0, 0, 0, 0, 0, 0);
        run_scan("post", 100, 256, 15, 1'b0, 1'b0);
        chk_outs("post", 1, 0, 0, 0, 256, 0, 0, 0);

        for (int r = 0; r < 16; r++) begin
            int rx, ry, rs;
            for (int i = 0; i < 1200; i++) map_mem[i] = ($urandom_range(0, 3) == 0);
            rx = $urandom_range(0, 660);
            ry = $urandom_range(0, 500);
            rs = $urandom_range(0, 40);
            run_scan($sformatf("rnd%0d", r), rx, ry, rs, 1'b0, 1'b0);
            chk_outs($sformatf("rnd%0d", r), m_td, m_tu, m_tl, m_tr, m_dpy, m_upy, m_lpx, m_rpx);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/collision_scan.md
# collision_scan

Tile-map collision detector driving the player's contact inputs (touch_* flags, snap positions, logic_in_air). Once per frame_clk rising edge it snapshots the player box, probes eight points around it in the 40x30 tile map, and commits all results together. It sits between the tile-map ROM/BRAM and the player motion block, running on the system clock.

## Interface
- TILE_SHIFT, 4: log2 of tile edge in pixels (16 px tiles).
- MAP_COLS, 40: tiles per row; map address = row*MAP_COLS + col.
- SCREEN_W, 640: probe x >= SCREEN_W is out of range.
- SCREEN_H, 480: probe y >= SCREEN_H is out of range.

- Clk  in  1  system clock; all logic on its rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- frame_clk  in  1  frame tick; a rising edge requests a scan. Asynchronous to Clk.
- BallX, BallY, BallS  in  10 each  player centre and half-size, unsigned pixels.
- map_addr  out  11  tile-map read address.
- map_data  in  1  solid bit, valid one Clk after map_addr.
- touch_down, touch_up, touch_left, touch_right  out  1 each  contact flags.
- touch_down_position_y, touch_up_position_y  out  10 each  snap centre Y.
- touch_left_position_x, touch_right_position_x  out  10 each  snap centre X.
- logic_in_air  out  1  equals !touch_down.
- scan_done  out  1  one-cycle pulse when the results are committed.
- scan_overrun  out  1  sticky; a frame edge arrived while busy.

## Operation
- frame_clk passes through a 2-flop synchronizer plus an edge register. `start` is a 1-cycle pulse on a synchronized 0->1 transition.
- States:
  - IDLE: on `start`, snapshot BallX/BallY/BallS, clear the hit accumulators, set k=0, go to PROBE.
  - PROBE: drive map_addr for probe k. Go to CHECK.
  - CHECK: OR the probe result into its side's accumulator, k++. Go to COMMIT after k=7, else PROBE.
  - COMMIT: register all outputs, pulse scan_done. Return to IDLE.
- All probe arithmetic is 10-bit modulo 1024, using the snapshot values X, Y, S. Negative results wrap to large values and are therefore out of range.
- Probe order (x, y):
  - 0: (X-S, Y+S+1)
  - 1: (X+S, Y+S+1)
  - 2: (X-S, Y-S-1)
  - 3: (X+S, Y-S-1)
  - 4: (X-S-1, Y-S)
  - 5: (X-S-1, Y+S)
  - 6: (X+S+1, Y-S)
  - 7: (X+S+1, Y+S)
- Probes 0-1 feed down, 2-3 up, 4-5 left, 6-7 right.
- In-range probe: map_addr = (y>>4)*40 + (x>>4). The result is map_data sampled in CHECK.
- Out-of-range probe: map_addr holds 0 and map_data is ignored.
  - Result = solid only for probes 0-1 with y >= SCREEN_H (floor), provided x is in range.
  - Result = not solid in every other out-of-range case.
- Snap positions depend only on the side's shared probe coordinate (yd=Y+S+1, yu=Y-S-1, xl=X-S-1, xr=X+S+1):
  - touch_down_position_y = ((yd>>4)<<4) - 1 - S; floor case = 479 - S.
  - touch_up_position_y = (((yu>>4)+1)<<4) + S.
  - touch_left_position_x = (((xl>>4)+1)<<4) + S.
  - touch_right_position_x = ((xr>>4)<<4) - 1 - S.
- A position is 0 whenever its flag is 0.
- Outputs hold between commits. No output changes outside COMMIT.
- A `start` seen outside IDLE is dropped and sets scan_overrun, which stays 1 until reset. The running scan completes normally.

## Timing
- Reset values: all touch_* 0, all positions 0, logic_in_air 1, scan_done 0, scan_overrun 0, map_addr 0, state IDLE, k 0.
- Reset_n low mid-scan: immediate return to reset values. No scan_done; the partial scan is discarded.
- frame_clk rising edge to `start`: 3 Clk cycles.
- Let E0 be the Clk edge on which IDLE accepts `start`:
  - probe k address is valid after E(2k+1);
  - its data is sampled at E(2k+2);
  - outputs and scan_done=1 appear after E17;
  - scan_done drops after E18.
- Scan duration is 17 cycles. The next `start` is accepted from E18 onward.

## Test plan
- All-empty map, ball (320,240,15), one frame edge -> all touch 0, logic_in_air 1, positions 0, single scan_done exactly 17 cycles after `start` acceptance.
- Row 17 solid (y 272-287), ball (100,256,15) -> touch_down 1, touch_down_position_y 256, logic_in_air 0. Check the map_addr sequence: probes 0,1 give 17*40+5=685 and 17*40+7=687.
- Column 5 solid, ball (111,200,15) -> touch_left 1, touch_left_position_x 111. Column 10 solid, ball (144,200,15) -> touch_right 1, touch_right_position_x 144.
- Empty map, ball (10,470,15) -> left probes wrap (x=1018), so touch_left 0. Bottom probe y=486 is floor: touch_down 1, touch_down_position_y 464. Ball (100,15,15) -> up probe wraps, so touch_up 0.
- Second frame_clk rise 5 cycles after `start` -> scan_overrun 1 (sticky), exactly one scan_done, results of the first snapshot.
- Reset_n low at cycle 9 of a scan with row 17 solid -> outputs at reset values and no scan_done. After release, the next frame edge gives touch_down 1 after 17 cycles.
